// File: rtl/sbox_rr_arbiter_if.sv
// Requester-side bundle of the shared S-box arbiter: request and response valid/ready channels.
// master = requester side, slave = arbiter side.
interface sbox_rr_arbiter_if #(
  parameter int unsigned NumReq = 4
);
  logic [NumReq-1:0]   req_valid;
  logic [NumReq-1:0]   req_ready;
  logic [8*NumReq-1:0] req_data;
  logic [NumReq-1:0]   req_inv;
  logic [NumReq-1:0]   rsp_valid;
  logic [NumReq-1:0]   rsp_ready;
  logic [7:0]          rsp_data;

  modport master (
    output req_valid, req_data, req_inv, rsp_ready,
    input  req_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, req_data, req_inv, rsp_ready,
    output req_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/sbox_rr_arbiter.sv
// Round-robin arbiter that time-shares one S-box/inverse S-box datapath between NumReq clients.
// One transaction in flight: IDLE grant -> CALC wait SboxLat cycles -> RESP until accepted.
module sbox_rr_arbiter #(
  parameter int unsigned NumReq  = 4,
  parameter int unsigned SboxLat = 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  sbox_rr_arbiter_if.slave  bus,
  output logic [7:0]        sbox_x_o,
  output logic              sbox_decrypt_o,
  input  logic [7:0]        sbox_y_i,
  output logic              busy_o,
  output logic [15:0]       op_count_o
);
  localparam int unsigned IdW  = (NumReq > 1) ? $clog2(NumReq) : 1;
  localparam int unsigned LatW = $clog2(SboxLat + 1);

  typedef enum logic [1:0] {StIdle, StCalc, StResp} state_e;

  state_e          state_q, state_d;
  logic [IdW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [IdW-1:0]  gnt_id_q, gnt_id_d;
  logic [LatW-1:0] lat_cnt_q, lat_cnt_d;
  logic [7:0]      sbox_x_q, sbox_x_d;
  logic            sbox_dec_q, sbox_dec_d;
  logic [7:0]      rsp_data_q, rsp_data_d;
  logic [15:0]     op_count_q, op_count_d;

  logic [IdW-1:0]  win_id;
  logic            win_found;
  logic [7:0]      win_data;
  int unsigned     cand_idx;

  // First valid requester at or after rr_ptr, wrapping modulo NumReq.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    cand_idx  = 0;
    for (int unsigned k = 0; k < NumReq; k++) begin
      cand_idx = (32'(rr_ptr_q) + k) % NumReq;
      if (!win_found && bus.req_valid[IdW'(cand_idx)]) begin
        win_found = 1'b1;
        win_id    = IdW'(cand_idx);
      end
    end
  end

  assign win_data = bus.req_data[{win_id, 3'b000} +: 8];

  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    gnt_id_d      = gnt_id_q;
    lat_cnt_d     = lat_cnt_q;
    sbox_x_d      = sbox_x_q;
    sbox_dec_d    = sbox_dec_q;
    rsp_data_d    = rsp_data_q;
    op_count_d    = op_count_q;
    bus.req_ready = '0;
    bus.rsp_valid = '0;
    unique case (state_q)
      StIdle: begin
        if (win_found) begin
          bus.req_ready[win_id] = 1'b1;
          sbox_x_d              = win_data;
          sbox_dec_d            = bus.req_inv[win_id];
          gnt_id_d              = win_id;
          lat_cnt_d             = LatW'(SboxLat);
          state_d               = StCalc;
        end
      end
      StCalc: begin
        lat_cnt_d = lat_cnt_q - LatW'(1);
        if (lat_cnt_q == LatW'(1)) begin
          rsp_data_d = sbox_y_i;
          state_d    = StResp;
        end
      end
      StResp: begin
        bus.rsp_valid[gnt_id_q] = 1'b1;
        // Only the granted requester's rsp_ready can complete the transaction.
        if (bus.rsp_ready[gnt_id_q]) begin
          state_d    = StIdle;
          rr_ptr_d   = (gnt_id_q == IdW'(NumReq - 1)) ? '0 : gnt_id_q + IdW'(1);
          op_count_d = op_count_q + 16'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      rr_ptr_q   <= '0;
      gnt_id_q   <= '0;
      lat_cnt_q  <= '0;
      sbox_x_q   <= 8'h00;
      sbox_dec_q <= 1'b0;
      rsp_data_q <= 8'h00;
      op_count_q <= 16'h0000;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      gnt_id_q   <= gnt_id_d;
      lat_cnt_q  <= lat_cnt_d;
      sbox_x_q   <= sbox_x_d;
      sbox_dec_q <= sbox_dec_d;
      rsp_data_q <= rsp_data_d;
      op_count_q <= op_count_d;
    end
  end

  assign bus.rsp_data   = rsp_data_q;
  assign sbox_x_o       = sbox_x_q;
  assign sbox_decrypt_o = sbox_dec_q;
  assign busy_o         = (state_q != StIdle);
  assign op_count_o     = op_count_q;
endmodule
